fifo_burst_read: RTL and testbench
==================================

# fifo_burst_read

Parametrised successor to the single-length FIFO reader. On an `fs` request it pops a runtime-selected number of words from a standard (non-FWFT) FIFO, packs them MSB-first into a wide result bus, and signals completion on `fd`. It pauses on `fifo_empty` instead of over-reading, and flags length and underrun errors. It sits between the data FIFO and consumers such as the LED register display or the UDP TX path, on the FIFO read clock.

## Interface
Parameters:
- `DATA_W`, 8: FIFO word width in bits.
- `MAX_WORDS`, 12: capacity of `res` in words.
- `LEN_W`, 12: width of `data_len`.
- `TIMEOUT`, 1024: consecutive empty cycles before abort. Used only under the configuration macro.

Ports:
- `clk`  in  1: single clock. All logic is on its rising edge.
- `rst`  in  1: reset is synchronous and active-high.
- `fs`  in  1: start request, level. Sampled only in IDLE and DONE.
- `fd`  out  1: done. High throughout DONE.
- `err`  out  1: error qualifier. Valid only while `fd` is high.
- `data_len`  in  LEN_W: number of words to read. Sampled on the IDLE→READ edge.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rxen`  out  1: FIFO read enable.
- `fifo_rxd`  in  DATA_W: FIFO data out. Valid the cycle after a `fifo_rxen`-high edge.
- `res`  out  MAX_WORDS*DATA_W: packed result. Word 0 occupies the top DATA_W bits.
- `rd_cnt`  out  LEN_W: number of words captured in the current or last burst.

## Operation
- States: IDLE, READ, DONE.
- IDLE → READ when `fs`=1.
  - Latches `len = min(data_len, MAX_WORDS)`.
  - Sets internal `len_err` if `data_len > MAX_WORDS`.
  - Clears the shadow buffer, the issue counter and `rd_cnt`.
- IDLE → DONE when `fs`=1 and `data_len`=0. `res` is cleared and `err`=0.
- READ, read issue:
  - `fifo_rxen = (state==READ) && !fifo_empty && (issued < len)`.
  - `issued` increments on every edge where `fifo_rxen` is high.
- READ, data capture:
  - A 1-cycle delayed copy of `fifo_rxen` (`cap`) marks valid `fifo_rxd`.
  - When `cap` is high, `fifo_rxd` is written to shadow word `rd_cnt`, i.e. bits `[(MAX_WORDS-rd_cnt)*DATA_W-1 -: DATA_W]`.
  - `rd_cnt` increments on each capture.
- READ → DONE on the edge where the capture makes `rd_cnt == len`.
  - The shadow buffer is copied to `res` on the same edge, so `res` never shows a partially filled burst, except after a timeout.
  - Unfilled low words of `res` are zero.
- DONE: `fd`=1, `err` = `len_err` (or the timeout flag). DONE → IDLE when `fs`=0.
- DONE → IDLE clears `fd`, `err` and the internal error flags. `res` and `rd_cnt` hold their values.
- `fs` going low during READ is ignored; the burst always completes.
- `fifo_empty` during READ stalls issue only. A capture already in flight still completes.
- Counters use LEN_W-bit unsigned arithmetic and never exceed `len`. There is no wrap-around.

## Timing
- Reset values: state IDLE, `fd`=0, `err`=0, `fifo_rxen`=0, `res`=0, `rd_cnt`=0.
- Reset mid-burst: the block is back in IDLE on the next edge. Popped words are discarded and the FIFO itself is not reset.
- Let edge E0 be the edge that samples `fs`=1 in IDLE.
  - With a non-empty FIFO and `len`=N, `fifo_rxen` is high for cycles E0..E(N-1).
  - `fd` rises after edge E(N+1), i.e. N+1 edges after E0.
- Each cycle of `fifo_empty` seen during issue adds one cycle to that latency.
- Throughput: one word per clock while the FIFO is non-empty.
- Minimum turnaround: `fs` low for 1 cycle in DONE, then high again, starts the next burst 2 edges after DONE is entered.

## Configuration
- `FIFO_BURST_TIMEOUT_EN` defined:
  - A counter runs while in READ with `issued < len` and `fifo_empty`=1. It resets on any issue.
  - When it reaches TIMEOUT, the block goes READ → DONE with `err`=1.
  - `res` is loaded with the partial shadow buffer and `rd_cnt` equals the number of words captured.
- `FIFO_BURST_TIMEOUT_EN` undefined: READ waits indefinitely for data, and `err` reflects only `len_err`.

## Structure
- Shared package `fifo_pkg`:
  - State encoding localparams (IDLE=2'd0, READ=2'd1, DONE=2'd2).
  - A `clog2` function for sizing the timeout counter.
  - Default DATA_W, MAX_WORDS, LEN_W.
- One sub-module, `fifo_rd_timeout`: the empty-cycle counter and its compare. It is instantiated only under `FIFO_BURST_TIMEOUT_EN`.

## Test plan
- FIFO preloaded with 0x01..0x0C, `data_len`=12, `fs` held high until `fd` → `fifo_rxen` high for exactly 12 cycles; `fd` rises 13 edges after E0; `res`=96'h0102030405060708090A0B0C; `rd_cnt`=12; `err`=0.
- `data_len`=3 with 0xAA,0xBB,0xCC → `res`=96'hAABBCC000000000000000000; `fd`=1; `err`=0.
- `data_len`=20 with 12 words loaded → 12 words read; `fd`=1 with `err`=1; `rd_cnt`=12.
- FIFO empty for 5 cycles after word 4 of 12 → `fifo_rxen` never high while `fifo_empty`=1; `fd` delayed by 5 cycles; data correct. With the macro defined and TIMEOUT=4 instead: `fd`=1, `err`=1, `rd_cnt`=4, words 4..11 of `res` zero.
- `rst` pulsed mid-burst after 6 reads → next edge: IDLE, `res`=0, `rd_cnt`=0, `fifo_rxen`=0. A subsequent `data_len`=0 request → immediate DONE with `fd`=1, `err`=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared state encoding, default sizes and helpers for the FIFO burst reader
package fifo_pkg;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_MAX_WORDS = 12;
   localparam int DEF_LEN_W     = 12;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] READ = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_READ = READ,
      ST_DONE = DONE
   } state_t;

   // Bits needed to hold values 0..value-1; never less than one bit.
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'd1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_rd_timeout.sv
// rtl/fifo_rd_timeout.sv - consecutive empty-cycle counter that aborts a stalled burst
// Instantiated by fifo_burst_read only when FIFO_BURST_TIMEOUT_EN is defined.
module fifo_rd_timeout
   import fifo_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic hit
);

   localparam int CNT_W = clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Fires on the cycle that would make the count reach TIMEOUT.
   assign hit = run && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (!run || hit) cnt_d = '0;
      else             cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/fifo_burst_read.sv
// rtl/fifo_burst_read.sv - pops a runtime-length burst from a standard FIFO and packs it MSB-first
// Optional empty-cycle abort is built in when FIFO_BURST_TIMEOUT_EN is defined.
module fifo_burst_read
   import fifo_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_WORDS = DEF_MAX_WORDS,
   parameter int LEN_W     = DEF_LEN_W,
   parameter int TIMEOUT   = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        fs,
   output logic                        fd,
   output logic                        err,
   input  logic [LEN_W-1:0]            data_len,
   input  logic                        fifo_empty,
   output logic                        fifo_rxen,
   input  logic [DATA_W-1:0]           fifo_rxd,
   output logic [MAX_WORDS*DATA_W-1:0] res,
   output logic [LEN_W-1:0]            rd_cnt
);

   localparam int               RES_W   = MAX_WORDS * DATA_W;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] issued_q, issued_d;
   logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [LEN_W-1:0] rd_cnt_inc;
   logic             len_err_q, len_err_d;
   logic             err_q, err_d;
   logic             cap_q, cap_d;
   logic [RES_W-1:0] shadow_q, shadow_d, shadow_wr;
   logic [RES_W-1:0] res_q, res_d;
   logic             rxen;
   logic             timeout_hit;

   assign rxen       = (state_q == ST_READ) && !fifo_empty && (issued_q < len_q);
   assign rd_cnt_inc = rd_cnt_q + LEN_W'(1);

`ifdef FIFO_BURST_TIMEOUT_EN
   logic tmo_run;
   assign tmo_run = (state_q == ST_READ) && fifo_empty && (issued_q < len_q);

   fifo_rd_timeout #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk (clk),
      .rst (rst),
      .run (tmo_run),
      .hit (timeout_hit)
   );
`else
   localparam int unused_timeout = TIMEOUT;
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      shadow_wr = shadow_q;
      for (int w = 0; w < MAX_WORDS; w++) begin
         if (rd_cnt_q == LEN_W'(w)) shadow_wr[(MAX_WORDS-w)*DATA_W-1 -: DATA_W] = fifo_rxd;
      end
   end

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      issued_d  = issued_q;
      rd_cnt_d  = rd_cnt_q;
      len_err_d = len_err_q;
      err_d     = err_q;
      shadow_d  = shadow_q;
      res_d     = res_q;
      cap_d     = rxen;

      case (state_q)
         ST_IDLE: begin
            if (fs) begin
               len_err_d = (data_len > MAX_LEN);
               len_d     = (data_len > MAX_LEN) ? MAX_LEN : data_len;
               issued_d  = '0;
               rd_cnt_d  = '0;
               shadow_d  = '0;
               if (data_len == '0) begin
                  state_d = ST_DONE;
                  res_d   = '0;
                  err_d   = 1'b0;
               end else begin
                  state_d = ST_READ;
               end
            end
         end
         ST_READ: begin
            if (rxen) issued_d = issued_q + LEN_W'(1);
            if (cap_q) begin
               shadow_d = shadow_wr;
               rd_cnt_d = rd_cnt_inc;
            end
            // res only ever sees a complete burst, or the partial one on abort.
            if ((cap_q && (rd_cnt_inc == len_q)) || timeout_hit) begin
               state_d = ST_DONE;
               res_d   = cap_q ? shadow_wr : shadow_q;
               err_d   = len_err_q || timeout_hit;
            end
         end
         ST_DONE: begin
            if (!fs) begin
               state_d   = ST_IDLE;
               err_d     = 1'b0;
               len_err_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         issued_q  <= '0;
         rd_cnt_q  <= '0;
         len_err_q <= 1'b0;
         err_q     <= 1'b0;
         cap_q     <= 1'b0;
         shadow_q  <= '0;
         res_q     <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         issued_q  <= issued_d;
         rd_cnt_q  <= rd_cnt_d;
         len_err_q <= len_err_d;
         err_q     <= err_d;
         cap_q     <= cap_d;
         shadow_q  <= shadow_d;
         res_q     <= res_d;
      end
   end

   assign fd        = (state_q == ST_DONE);
   assign err       = err_q;
   assign fifo_rxen = rxen;
   assign res       = res_q;
   assign rd_cnt    = rd_cnt_q;

endmodule

// File: tb/tb_fifo_burst_read.sv
// tb/tb_fifo_burst_read.sv - randomized and directed bursts against a queue-based reference
// FIFO_BURST_TIMEOUT_EN selects the timeout expectations for the stall case.
module tb_fifo_burst_read;

`ifdef FIFO_BURST_TIMEOUT_EN
   localparam int TB_TIMEOUT = 4;
   localparam bit TMO_EN     = 1'b1;
`else
   localparam int TB_TIMEOUT = 1024;
   localparam bit TMO_EN     = 1'b0;
`endif
   localparam int MW = 12;

   logic        clk = 1'b0;
   logic        rst;
   logic        fs;
   logic        fd;
   logic        err;
   logic [11:0] data_len;
   logic        fifo_empty;
   logic        fifo_rxen;
   logic [7:0]  fifo_rxd;
   logic [95:0] res;
   logic [11:0] rd_cnt;

   logic [7:0] fifo_q[$];
   int pops, st_after, st_rem, rxen_cycles, rxen_viol;
   bit stall;
   int n_checks = 0;
   int n_fail   = 0;

   fifo_burst_read #(
      .DATA_W(8), .MAX_WORDS(MW), .LEN_W(12), .TIMEOUT(TB_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .fs(fs), .fd(fd), .err(err), .data_len(data_len),
      .fifo_empty(fifo_empty), .fifo_rxen(fifo_rxen), .fifo_rxd(fifo_rxd),
      .res(res), .rd_cnt(rd_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample mid-cycle, then model the FIFO's registered read port after the edge.
   task automatic tick();
      bit pop;
      @(negedge clk);
      pop = fifo_rxen && !fifo_empty;
      if (fifo_rxen) rxen_cycles++;
      if (fifo_rxen && fifo_empty) rxen_viol++;
      @(posedge clk);
      #1;
      if (pop && fifo_q.size() > 0) begin
         fifo_rxd = fifo_q.pop_front();
         pops++;
      end
      if (pops == st_after && st_rem > 0) begin
         stall = 1'b1;
         st_rem--;
      end else begin
         stall = 1'b0;
      end
      fifo_empty = stall || (fifo_q.size() == 0);
   endtask

   task automatic run_burst(input string name, input int len, input int pattern,
                            input int stall_after, input int stall_len, input int extra,
                            input bit expect_tmo);
      int n, kept, cyc, exp_lat;
      bit seen;
      logic [7:0]  w;
      logic [95:0] exp_res, res_at_done;
      n    = (len > MW) ? MW : len;
      kept = expect_tmo ? stall_after : n;
      exp_res = '0;
      fifo_q.delete();
      for (int i = 0; i < n + extra; i++) begin
         case (pattern)
            1:       w = 8'(i + 1);
            2:       w = 8'(8'hAA + 8'h11 * i);
            default: w = 8'($urandom);
         endcase
         fifo_q.push_back(w);
         if (i < kept) exp_res[(MW-i)*8-1 -: 8] = w;
      end
      pops = 0; st_after = stall_after; st_rem = stall_len;
      rxen_cycles = 0; rxen_viol = 0; stall = 1'b0;
      fifo_empty = (fifo_q.size() == 0);
      data_len = 12'(len);
      fs = 1'b1;
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 300) begin
         tick();
         cyc++;
         if (fd) seen = 1'b1;
      end
      check_eq({name, ":fd"}, seen, 1'b1);
      if (!expect_tmo) begin
         exp_lat = (n == 0) ? 1 : n + 2 + ((stall_after < n) ? stall_len : 0);
         check_eq({name, ":latency"}, cyc, exp_lat);
      end
      check_eq({name, ":rxen_cycles"}, rxen_cycles, kept);
      check_eq({name, ":rxen_while_empty"}, rxen_viol, 0);
      check_eq({name, ":res"}, res, exp_res);
      check_eq({name, ":rd_cnt"}, rd_cnt, kept);
      check_eq({name, ":err"}, err, (len > MW) || expect_tmo);
      check_eq({name, ":fifo_left"}, fifo_q.size(), n + extra - kept);
      res_at_done = res;
      fs = 1'b0;
      tick();
      check_eq({name, ":fd_clear"}, fd, 1'b0);
      check_eq({name, ":err_clear"}, err, 1'b0);
      check_eq({name, ":res_hold"}, res, res_at_done);
      check_eq({name, ":rd_cnt_hold"}, rd_cnt, kept);
   endtask

   initial begin
      int len, n, sa, sl;
      rst = 1'b1; fs = 1'b0; data_len = '0; fifo_empty = 1'b1; fifo_rxd = '0;
      pops = 0; st_after = -1; st_rem = 0; stall = 1'b0;
      repeat (3) tick();
      check_eq("reset:fd", fd, 1'b0);
      check_eq("reset:err", err, 1'b0);
      check_eq("reset:rxen", fifo_rxen, 1'b0);
      check_eq("reset:res", res, 96'h0);
      check_eq("reset:rd_cnt", rd_cnt, 12'd0);
      rst = 1'b0;
      tick();

      run_burst("inc12", 12, 1, -1, 0, 2, 1'b0);
      run_burst("abc3", 3, 2, -1, 0, 1, 1'b0);
      check_eq("abc3:value", res, 96'hAABBCC000000000000000000);
      run_burst("len20", 20, 0, -1, 0, 0, 1'b0);
      run_burst("stall5", 12, 1, 4, 5, 0, TMO_EN);

      for (int k = 0; k < 8; k++) begin
         len = $urandom_range(1, 15);
         n   = (len > MW) ? MW : len;
         sa  = $urandom_range(0, n - 1);
         sl  = TMO_EN ? $urandom_range(0, TB_TIMEOUT - 1) : $urandom_range(0, 6);
         run_burst($sformatf("rnd%0d", k), len, 0, sa, sl, $urandom_range(0, 3), 1'b0);
      end

      // Reset in the middle of a burst.
      fifo_q.delete();
      for (int i = 0; i < MW; i++) fifo_q.push_back(8'($urandom));
      pops = 0; st_after = -1; st_rem = 0; stall = 1'b0;
      fifo_empty = 1'b0;
      data_len = 12'd12;
      fs = 1'b1;
      for (int c = 0; c < 50 && pops < 6; c++) tick();
      check_eq("midrst:pops", pops, 6);
      rst = 1'b1;
      tick();
      check_eq("midrst:rxen", fifo_rxen, 1'b0);
      check_eq("midrst:res", res, 96'h0);
      check_eq("midrst:rd_cnt", rd_cnt, 12'd0);
      check_eq("midrst:fd", fd, 1'b0);
      rst = 1'b0;
      fs = 1'b0;
      tick();
      run_burst("zero", 0, 0, -1, 0, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
